// File: rtl/mult_arb_pkg.sv
// Shared constants and the in-flight tag record for the mult_arb scheduler.
package mult_pkg;

   localparam int SIZE_DEF  = 16;
   localparam int NREQ_DEF  = 4;
   localparam int LVL_DEF   = 2;
   localparam int IDXW      = $clog2(NREQ_DEF);
   // Tag index field is wide enough for any practical requester count.
   localparam int TAG_IDX_W = 8;

   typedef struct packed {
      logic                 vld;
      logic [TAG_IDX_W-1:0] idx;
   } tag_t;

endpackage

// File: rtl/mult_arb_rr_grant.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_grant #(
   parameter int NREQ = 4,
   parameter int PTRW = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [PTRW-1:0] ptr,
   input  logic            en,
   output logic [NREQ-1:0] grant,
   output logic [PTRW-1:0] idx,
   output logic            any
);

   logic [PTRW-1:0] pos;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      pos   = '0;
      for (int k = 0; k < NREQ; k++) begin
         pos = PTRW'((int'(ptr) + k) % NREQ);
         if (en && !any && req[pos]) begin
            grant[pos] = 1'b1;
            idx        = pos;
            any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mult_arb.sv
// Round-robin scheduler sharing one LVL-stage multiplier among NREQ requesters.
// Optional per-requester saturating grant counters under MULT_ARB_CNT_EN.
module mult_arb
   import mult_pkg::*;
#(
   parameter int SIZE = SIZE_DEF,
   parameter int NREQ = NREQ_DEF,
   parameter int LVL  = LVL_DEF,
   parameter int CNTW = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 hold,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*SIZE-1:0] req_a,
   input  logic [NREQ*SIZE-1:0] req_b,
   output logic [SIZE-1:0]      mul_a,
   output logic [SIZE-1:0]      mul_b,
   input  logic [2*SIZE-1:0]    mul_pdt,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [2*SIZE-1:0]    rsp_pdt,
   output logic                 busy
`ifdef MULT_ARB_CNT_EN
   ,
   output logic [NREQ*CNTW-1:0] grant_cnt
`endif
);

   localparam int PTRW = $clog2(NREQ);

   logic [PTRW-1:0] ptr;
   logic [PTRW-1:0] gidx;
   logic [NREQ-1:0] grant;
   logic            gany;
   tag_t            tag_p [LVL];

   // Reset also masks grants so nothing is issued while the pipe is being cleared.
   rr_grant #(
      .NREQ (NREQ),
      .PTRW (PTRW)
   ) u_rr_grant (
      .req   (req_valid),
      .ptr   (ptr),
      .en    (!hold && !rst),
      .grant (grant),
      .idx   (gidx),
      .any   (gany)
   );

   assign req_ready = grant;

   always_comb begin
      mul_a = '0;
      mul_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            mul_a = req_a[i*SIZE +: SIZE];
            mul_b = req_b[i*SIZE +: SIZE];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (gany) begin
         ptr <= (gidx == PTRW'(NREQ - 1)) ? '0 : gidx + 1'b1;
      end
   end

   // ---- issue -> tag_p[0] ... tag_p[LVL-1] -> response, in step with the multiplier
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < LVL; s++) begin
            tag_p[s] <= '0;
         end
      end else begin
         tag_p[0] <= {gany, TAG_IDX_W'(gidx)};
         for (int s = 1; s < LVL; s++) begin
            tag_p[s] <= tag_p[s-1];
         end
      end
   end

   always_comb begin
      rsp_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (tag_p[LVL-1].vld && (tag_p[LVL-1].idx == TAG_IDX_W'(i))) begin
            rsp_valid[i] = 1'b1;
         end
      end
   end

   assign rsp_pdt = mul_pdt;

   always_comb begin
      busy = 1'b0;
      for (int s = 0; s < LVL; s++) begin
         busy = busy | tag_p[s].vld;
      end
   end

`ifdef MULT_ARB_CNT_EN
   logic [CNTW-1:0] cnt [NREQ];

   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREQ; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
               cnt[i] <= sat_inc(cnt[i]);
            end
         end
      end
   end

   always_comb begin
      grant_cnt = '0;
      for (int i = 0; i < NREQ; i++) begin
         grant_cnt[i*CNTW +: CNTW] = cnt[i];
      end
   end
`endif

endmodule
